mat_row_server: RTL and testbench

- Row-storage responder for the triangular-matrix inverter's row-read interface.
- Holds a SIZE x SIZE complex matrix loaded row-by-row by an upstream writer.
- Answers the inverter's row address requests with a registered row, the echoed address and a valid pulse.
- Holds a request for a not-yet-loaded row until that row is written, so the inverter can start before loading completes.

---
 rtl/tri_inv_pkg.sv | 20 ++
 rtl/mat_row_bank.sv | 57 +++++
 rtl/mat_row_server.sv | 126 ++++++++++++
 tb/tb_mat_row_server.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_inv_pkg.sv
// Shared types for the triangular-matrix inverter row server: complex element,
// row type, and the server's request FSM states.
package tri_inv_pkg;

    localparam int TRI_SIZE  = 8;
    localparam int TRI_WIDTH = 64;

    typedef struct packed {
        logic [TRI_WIDTH-1:0] im;
        logic [TRI_WIDTH-1:0] re;
    } cplx_t;

    typedef cplx_t [TRI_SIZE-1:0] row_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } srv_state_e;

endpackage

// File: rtl/mat_row_bank.sv
// SIZE-row register file: one write port, one combinational read port and the
// per-row loaded bitmap. Storage itself is never reset; only the bitmap is.
module mat_row_bank
    import tri_inv_pkg::*;
#(
    parameter int SIZE  = TRI_SIZE,
    parameter int WIDTH = TRI_WIDTH,
    localparam int AW    = $clog2(SIZE),
    localparam int ROW_W = SIZE * 2 * WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [ROW_W-1:0] wr_row_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [ROW_W-1:0] rd_row_o,
    output logic [SIZE-1:0]  loaded_o,
    output logic             all_loaded_o
);

    logic [ROW_W-1:0] mem_q [SIZE];
    logic [SIZE-1:0]  loaded_d, loaded_q;
    logic             all_loaded_d, all_loaded_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_row_i;
        end
    end

    always_comb begin
        loaded_d = loaded_q;
        if (flush_i) begin
            loaded_d = '0;
        end else if (wr_en_i) begin
            loaded_d[wr_addr_i] = 1'b1;
        end
        all_loaded_d = &loaded_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            loaded_q     <= '0;
            all_loaded_q <= 1'b0;
        end else begin
            loaded_q     <= loaded_d;
            all_loaded_q <= all_loaded_d;
        end
    end

    assign rd_row_o     = mem_q[rd_addr_i];
    assign loaded_o     = loaded_q;
    assign all_loaded_o = all_loaded_q;

endmodule

// File: rtl/mat_row_server.sv
// Row-read responder for the inverter: registered row responses, with a single
// pending slot that waits for a not-yet-loaded row to be written.
module mat_row_server
    import tri_inv_pkg::*;
#(
    parameter int SIZE  = TRI_SIZE,
    parameter int WIDTH = TRI_WIDTH,
    localparam int AW    = $clog2(SIZE),
    localparam int ROW_W = SIZE * 2 * WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic [ROW_W-1:0] wr_row_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic             wr_valid_i,
    input  logic [AW-1:0]    mat_row_addr_i,
    input  logic             mat_row_addr_valid_i,
    output logic [ROW_W-1:0] mat_row_o,
    output logic [AW-1:0]    mat_row_addr_o,
    output logic             mat_row_valid_o,
    output logic [SIZE-1:0]  loaded_o,
    output logic             all_loaded_o,
    output logic             stall_o,
    output logic             overflow_o
);

    srv_state_e       state_d, state_q;
    logic [AW-1:0]    pend_d, pend_q;
    logic [ROW_W-1:0] rsp_row_d, rsp_row_q;
    logic [AW-1:0]    rsp_addr_d, rsp_addr_q;
    logic             rsp_vld_d, rsp_vld_q;
    logic             ovf_d, ovf_q;

    logic [ROW_W-1:0] bank_row;
    logic [SIZE-1:0]  loaded;
    logic             req_fwd, pend_fwd;

    mat_row_bank #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) u_bank (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .wr_en_i      (wr_valid_i & ~flush_i),
        .wr_addr_i    (wr_addr_i),
        .wr_row_i     (wr_row_i),
        .rd_addr_i    (mat_row_addr_i),
        .rd_row_o     (bank_row),
        .loaded_o     (loaded),
        .all_loaded_o (all_loaded_o)
    );

    // Same-cycle writes are forwarded so a request never sees stale row data.
    assign req_fwd  = wr_valid_i && (wr_addr_i == mat_row_addr_i);
    assign pend_fwd = wr_valid_i && (wr_addr_i == pend_q);

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        rsp_row_d  = rsp_row_q;
        rsp_addr_d = rsp_addr_q;
        rsp_vld_d  = 1'b0;
        ovf_d      = ovf_q;
        if (flush_i) begin
            state_d = IDLE;
            pend_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mat_row_addr_valid_i) begin
                        if (loaded[mat_row_addr_i] || req_fwd) begin
                            rsp_vld_d  = 1'b1;
                            rsp_addr_d = mat_row_addr_i;
                            rsp_row_d  = req_fwd ? wr_row_i : bank_row;
                        end else begin
                            pend_d  = mat_row_addr_i;
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Only one request can be parked; anything else is lost.
                    if (mat_row_addr_valid_i) begin
                        ovf_d = 1'b1;
                    end
                    if (pend_fwd) begin
                        rsp_vld_d  = 1'b1;
                        rsp_addr_d = pend_q;
                        rsp_row_d  = wr_row_i;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            rsp_row_q  <= '0;
            rsp_addr_q <= '0;
            rsp_vld_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            rsp_row_q  <= rsp_row_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_vld_q  <= rsp_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    assign mat_row_o       = rsp_row_q;
    assign mat_row_addr_o  = rsp_addr_q;
    assign mat_row_valid_o = rsp_vld_q;
    assign loaded_o        = loaded;
    assign stall_o         = (state_q == WAIT);
    assign overflow_o      = ovf_q;

endmodule

// File: tb/tb_mat_row_server.sv
// Bench for mat_row_server: directed scenarios plus a randomized run, all
// checked every cycle against a behavioural row-server model.
module tb_mat_row_server;
    import tri_inv_pkg::*;

    localparam int SIZE  = 8;
    localparam int WIDTH = 64;
    localparam int AW    = 3;
    localparam int EW    = 2 * WIDTH;
    localparam int ROW_W = SIZE * EW;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic [ROW_W-1:0] wr_row = '0;
    logic [AW-1:0]    wr_addr = '0;
    logic             wr_valid = 1'b0;
    logic [AW-1:0]    req_addr = '0;
    logic             req = 1'b0;
    logic [ROW_W-1:0] mat_row;
    logic [AW-1:0]    mat_row_addr;
    logic             mat_row_valid;
    logic [SIZE-1:0]  loaded;
    logic             all_loaded;
    logic             stall;
    logic             overflow;

    int cmp_n = 0;
    int bad_n = 0;

    mat_row_server #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .flush_i              (flush),
        .wr_row_i             (wr_row),
        .wr_addr_i            (wr_addr),
        .wr_valid_i           (wr_valid),
        .mat_row_addr_i       (req_addr),
        .mat_row_addr_valid_i (req),
        .mat_row_o            (mat_row),
        .mat_row_addr_o       (mat_row_addr),
        .mat_row_valid_o      (mat_row_valid),
        .loaded_o             (loaded),
        .all_loaded_o         (all_loaded),
        .stall_o              (stall),
        .overflow_o           (overflow)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [ROW_W-1:0] m_mem [SIZE];
    logic [SIZE-1:0]  m_loaded = '0;
    int               m_pend = -1;   // -1: no parked request
    logic             m_ovf = 1'b0;
    logic             m_vld = 1'b0;
    int               m_addr = 0;
    logic [ROW_W-1:0] m_row = '0;
    int               m_a;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_loaded = '0;
            m_pend   = -1;
            m_ovf    = 1'b0;
            m_vld    = 1'b0;
        end else begin
            m_vld = 1'b0;
            if (flush) begin
                m_loaded = '0;
                m_pend   = -1;
                m_ovf    = 1'b0;
            end else begin
                if (m_pend < 0) begin
                    if (req) begin
                        m_a = int'(req_addr);
                        if (wr_valid && wr_addr == req_addr) begin
                            m_vld = 1'b1; m_addr = m_a; m_row = wr_row;
                        end else if (m_loaded[m_a]) begin
                            m_vld = 1'b1; m_addr = m_a; m_row = m_mem[m_a];
                        end else begin
                            m_pend = m_a;
                        end
                    end
                end else begin
                    if (req) m_ovf = 1'b1;
                    if (wr_valid && int'(wr_addr) == m_pend) begin
                        m_vld = 1'b1; m_addr = m_pend; m_row = wr_row;
                        m_pend = -1;
                    end
                end
                if (wr_valid) begin
                    m_mem[int'(wr_addr)]    = wr_row;
                    m_loaded[int'(wr_addr)] = 1'b1;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_row(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        cmp_n++;
        if (act !== exp) begin
            bad_n++;
            for (int j = 0; j < SIZE; j++) begin
                if (act[j*EW +: EW] !== exp[j*EW +: EW]) begin
                    $display("FAIL %s elem %0d: got %0h expected %0h (t=%0t)",
                             name, j, act[j*EW +: EW], exp[j*EW +: EW], $time);
                    break;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", 64'(mat_row_valid), 64'd0);
            chk("rst_addr", 64'(mat_row_addr), 64'd0);
            chk_row("rst_row", mat_row, '0);
            chk("rst_loaded", 64'(loaded), 64'd0);
            chk("rst_all_loaded", 64'(all_loaded), 64'd0);
            chk("rst_stall", 64'(stall), 64'd0);
            chk("rst_overflow", 64'(overflow), 64'd0);
        end else begin
            chk("valid", 64'(mat_row_valid), 64'(m_vld));
            chk("loaded", 64'(loaded), 64'(m_loaded));
            chk("all_loaded", 64'(all_loaded), 64'(&m_loaded));
            chk("stall", 64'(stall), 64'(m_pend >= 0));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            if (m_vld) begin
                chk("rsp_addr", 64'(mat_row_addr), 64'(m_addr));
                chk_row("rsp_row", mat_row, m_row);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [ROW_W-1:0] mk_row(input int i);
        logic [ROW_W-1:0] r;
        cplx_t c;
        for (int j = 0; j < SIZE; j++) begin
            c.re = 64'(i * 8 + j);
            c.im = -64'(i * 8 + j);
            r[j*EW +: EW] = c;
        end
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] rnd_row();
        logic [ROW_W-1:0] r;
        for (int k = 0; k < ROW_W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        flush = 1'b0; wr_valid = 1'b0; req = 1'b0;
    endtask

    task automatic wr(input int a, input logic [ROW_W-1:0] d);
        wr_valid = 1'b1; wr_addr = AW'(a); wr_row = d;
    endtask

    task automatic rq(input int a);
        req = 1'b1; req_addr = AW'(a);
    endtask

    logic [ROW_W-1:0] row_b;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("init_valid", 64'(mat_row_valid), 64'd0);
        chk("init_stall", 64'(stall), 64'd0);
        rst = 1'b0;

        // full load, then 8 back-to-back reads
        for (int i = 0; i < SIZE; i++) begin
            wr(i, mk_row(i));
            cyc();
        end
        chk("lit_all_loaded", 64'(all_loaded), 64'd1);
        for (int i = 0; i < SIZE; i++) begin
            rq(i);
            cyc();
            chk("lit_b2b_valid", 64'(mat_row_valid), 64'd1);
            chk("lit_b2b_addr", 64'(mat_row_addr), 64'(i));
            if (i == 5) begin
                chk("lit_r5e3_re", mat_row[3*EW +: 64], 64'd43);
                chk("lit_r5e3_im", mat_row[3*EW + 64 +: 64], 64'hFFFF_FFFF_FFFF_FFD5);
            end
        end
        cyc();
        chk("lit_b2b_end", 64'(mat_row_valid), 64'd0);

        // stall on unloaded row 3, released by its write
        flush = 1'b1; cyc();
        rq(3); cyc();
        chk("lit_stall_set", 64'(stall), 64'd1);
        repeat (4) cyc();
        chk("lit_stall_hold", 64'(stall), 64'd1);
        wr(3, mk_row(30)); cyc();
        chk("lit_wait_valid", 64'(mat_row_valid), 64'd1);
        chk("lit_wait_addr", 64'(mat_row_addr), 64'd3);
        chk("lit_wait_re0", mat_row[63:0], 64'd240);
        chk("lit_stall_clr", 64'(stall), 64'd0);

        // overflow while waiting on row 5
        flush = 1'b1; cyc();
        wr(2, mk_row(2)); cyc();
        rq(5); cyc();
        rq(2); cyc();
        chk("lit_ovf_drop", 64'(mat_row_valid), 64'd0);
        chk("lit_ovf_set", 64'(overflow), 64'd1);
        wr(5, mk_row(5)); cyc();
        chk("lit_ovf_rsp_addr", 64'(mat_row_addr), 64'd5);
        chk("lit_ovf_rsp_valid", 64'(mat_row_valid), 64'd1);
        repeat (2) cyc();
        chk("lit_ovf_sticky", 64'(overflow), 64'd1);

        // same-cycle write + request forwards the new data
        wr(4, mk_row(1)); cyc();
        row_b = mk_row(9);
        wr(4, row_b); rq(4); cyc();
        chk("lit_fwd_valid", 64'(mat_row_valid), 64'd1);
        chk("lit_fwd_re0", mat_row[63:0], 64'd72);

        // flush beats a completing write in WAIT
        flush = 1'b1; cyc();
        rq(6); cyc();
        rq(1); cyc();
        flush = 1'b1; wr(6, mk_row(6)); cyc();
        chk("lit_flush_valid", 64'(mat_row_valid), 64'd0);
        chk("lit_flush_loaded", 64'(loaded), 64'd0);
        chk("lit_flush_stall", 64'(stall), 64'd0);
        chk("lit_flush_ovf", 64'(overflow), 64'd0);

        // async reset while a response is being presented
        wr(1, mk_row(1)); cyc();
        rq(1); cyc();
        #2 rst = 1'b1;
        #1;
        chk("lit_arst_valid", 64'(mat_row_valid), 64'd0);
        chk("lit_arst_loaded", 64'(loaded), 64'd0);
        chk("lit_arst_re0", mat_row[63:0], 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        rq(1); cyc();
        chk("lit_post_rst_stall", 64'(stall), 64'd1);
        chk("lit_post_rst_valid", 64'(mat_row_valid), 64'd0);
        wr(1, mk_row(11)); cyc();
        chk("lit_post_rst_rsp", 64'(mat_row_valid), 64'd1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            flush    = ($urandom_range(0, 63) == 0);
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_addr  = AW'($urandom_range(0, SIZE - 1));
            wr_row   = rnd_row();
            req      = ($urandom_range(0, 2) == 0);
            req_addr = AW'($urandom_range(0, SIZE - 1));
            @(posedge clk);
            #1;
        end
        cyc();
        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
        $finish;
    end

endmodule
